reg_bank_reader: RTL and testbench

//  Register bank (DEPTH x WIDTH) with one write port and a burst read port on a valid/ready handshake.

---
 rtl/reg_bank_reader_pkg.sv | 13 +
 rtl/reg_bank_mem.sv | 41 ++++
 rtl/reg_bank_reader.sv | 131 +++++++++++++
 tb/tb_reg_bank_reader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_reader_pkg.sv
// Shared constants and FSM encoding for the register bank burst reader.
package reg_bank_reader_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 8;

  // IDLE accepts new requests; BURST streams the remaining beats of a burst.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage

// File: rtl/reg_bank_mem.sv
// Storage array with one write port and a combinational read mux that
// forwards a same-cycle write to the read address (write-first).
module reg_bank_mem
  import reg_bank_reader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next contents: the addressed entry takes the write data, all others hold.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Entries clear on reset and otherwise load the next contents every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = (we && (waddr == rd_addr)) ? wdata : mem_q[rd_addr];

endmodule

// File: rtl/reg_bank_reader.sv
// Register bank with a burst read port: requests are accepted on a
// valid/ready handshake and the addressed entries stream out as registered
// beats, wrapping modulo DEPTH, with DLAST on the final beat.
module reg_bank_reader
  import reg_bank_reader_pkg::*;
#(
  parameter int  WIDTH = WIDTH_DEF,
  parameter int  DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             WE,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH-1:0] WDATA,
  input  logic             RD_VALID,
  output logic             RD_READY,
  input  logic [AW-1:0]    RADDR,
  input  logic [AW-1:0]    RLEN,
  output logic             DVALID,
  input  logic             DREADY,
  output logic [WIDTH-1:0] DOUT,
  output logic             DLAST,
  output logic             BUSY
);

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             dvalid_q, dvalid_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dlast_q, dlast_d;

  logic             free;
  logic             issue;
  logic             issue_last;
  logic [AW-1:0]    issue_addr;
  logic [WIDTH-1:0] rd_data;

  reg_bank_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (CLK),
    .rst_n   (RESETN),
    .we      (WE),
    .waddr   (WADDR),
    .wdata   (WDATA),
    .rd_addr (issue_addr),
    .rd_data (rd_data)
  );

  // Decide whether a beat issues this cycle, from where, and advance the burst.
  always_comb begin
    free       = !dvalid_q || DREADY;
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_addr = ptr_q;
    case (state_q)
      IDLE: begin
        if (RD_VALID && free) begin
          issue      = 1'b1;
          issue_addr = RADDR;
          issue_last = (RLEN == '0);
          if (RLEN != '0) begin
            ptr_d   = RADDR + 1'b1;
            cnt_d   = RLEN - 1'b1;
            state_d = BURST;
          end
        end
      end
      BURST: begin
        if (free) begin
          issue      = 1'b1;
          issue_last = (cnt_q == '0);
          ptr_d      = ptr_q + 1'b1;
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output slot: load on issue, drop valid when the slot drains, else hold.
  always_comb begin
    dvalid_d = dvalid_q;
    dout_d   = dout_q;
    dlast_d  = dlast_q;
    if (issue) begin
      dvalid_d = 1'b1;
      dout_d   = rd_data;
      dlast_d  = issue_last;
    end else if (free) begin
      dvalid_d = 1'b0;
    end
  end

  // FSM, burst counters and output beat register.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      dvalid_q <= 1'b0;
      dout_q   <= '0;
      dlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      dvalid_q <= dvalid_d;
      dout_q   <= dout_d;
      dlast_q  <= dlast_d;
    end
  end

  assign RD_READY = (state_q == IDLE) && free;
  assign BUSY     = (state_q == BURST);
  assign DVALID   = dvalid_q;
  assign DOUT     = dout_q;
  assign DLAST    = dlast_q;

endmodule

// File: tb/tb_reg_bank_reader.sv
// Self-checking bench for reg_bank_reader: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_reg_bank_reader;

  localparam int W  = 4;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] raddr;
  logic [AW-1:0] rlen;
  logic          dvalid;
  logic          dready;
  logic [W-1:0]  dout;
  logic          dlast;
  logic          busy;

  reg_bank_reader #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK      (clk),
    .RESETN   (rst_n),
    .WE       (we),
    .WADDR    (waddr),
    .WDATA    (wdata),
    .RD_VALID (rd_valid),
    .RD_READY (rd_ready),
    .RADDR    (raddr),
    .RLEN     (rlen),
    .DVALID   (dvalid),
    .DREADY   (dready),
    .DOUT     (dout),
    .DLAST    (dlast),
    .BUSY     (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: register contents, queue of addresses still owed to the
  // consumer for the current burst, and the beat sitting in the output slot.
  logic [W-1:0] m_mem [D];
  int           q_addr [$];
  bit           q_last [$];
  bit           m_dvalid;
  logic [W-1:0] m_dout;
  bit           m_dlast;

  int           taken [$];
  bit           taken_last [$];
  bit           pre_ready;

  typedef struct {
    bit           we;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    bit           rv;
    logic [AW-1:0] raddr;
    logic [AW-1:0] rlen;
    bit           dr;
    bit           e_ready;
    bit           e_dvalid;
    logic [W-1:0]  e_dout;
    bit           e_dlast;
    bit           e_busy;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t mk(int i_we, int i_wa, int i_wd, int i_rv, int i_ra, int i_rl, int i_dr,
                              int e_rdy, int e_dv, int e_do, int e_dl, int e_bz);
    vec_t v;
    v.we = i_we[0]; v.waddr = i_wa[AW-1:0]; v.wdata = i_wd[W-1:0];
    v.rv = i_rv[0]; v.raddr = i_ra[AW-1:0]; v.rlen = i_rl[AW-1:0]; v.dr = i_dr[0];
    v.e_ready = e_rdy[0]; v.e_dvalid = e_dv[0]; v.e_dout = e_do[W-1:0];
    v.e_dlast = e_dl[0]; v.e_busy = e_bz[0];
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    q_addr.delete();
    q_last.delete();
    m_dvalid = 1'b0;
    m_dout   = '0;
    m_dlast  = 1'b0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic modelStep();
    bit free;
    int a;
    bit l;
    free = !m_dvalid || dready;
    if (free) begin
      if (q_addr.size() == 0 && rd_valid) begin
        for (int i = 0; i <= int'(rlen); i++) begin
          q_addr.push_back((int'(raddr) + i) % D);
          q_last.push_back(i == int'(rlen));
        end
      end
      if (q_addr.size() != 0) begin
        a = q_addr.pop_front();
        l = q_last.pop_front();
        m_dout   = (we && int'(waddr) == a) ? wdata : m_mem[a];
        m_dvalid = 1'b1;
        m_dlast  = l;
      end else begin
        m_dvalid = 1'b0;
      end
    end
    if (we) m_mem[waddr] = wdata;
  endtask

  // One clock cycle: drive inputs, check handshake outputs before the edge,
  // then check the beat register after the edge.
  task automatic applyStimulus(input bit i_we, input logic [AW-1:0] i_waddr, input logic [W-1:0] i_wdata,
                               input bit i_rv, input logic [AW-1:0] i_raddr, input logic [AW-1:0] i_rlen,
                               input bit i_dr);
    we = i_we; waddr = i_waddr; wdata = i_wdata;
    rd_valid = i_rv; raddr = i_raddr; rlen = i_rlen; dready = i_dr;
    #1;
    pre_ready = rd_ready;
    checkOutput("rd_ready", 32'(rd_ready), 32'(q_addr.size() == 0 && (!m_dvalid || i_dr)));
    checkOutput("busy", 32'(busy), 32'(q_addr.size() != 0));
    if (dvalid && i_dr) begin
      taken.push_back(int'(dout));
      taken_last.push_back(dlast);
    end
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("dvalid", 32'(dvalid), 32'(m_dvalid));
    checkOutput("dout", 32'(dout), 32'(m_dout));
    checkOutput("dlast", 32'(dlast), 32'(m_dlast));
  endtask

  initial begin
    bit pat [4];
    int exp_beats [4];

    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    rd_valid = 1'b0; raddr = '0; rlen = '0; dready = 1'b0;
    modelReset();
    #12;
    checkOutput("reset_dvalid", 32'(dvalid), 32'd0);
    checkOutput("reset_dout", 32'(dout), 32'd0);
    checkOutput("reset_dlast", 32'(dlast), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a long burst over a fully written bank.
    for (int i = 0; i < D; i++) applyStimulus(1'b1, AW'(i), W'(i + 8), 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 3'd0, 3'd7, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    rst_n = 1'b0;
    #2;
    checkOutput("midburst_reset_dvalid", 32'(dvalid), 32'd0);
    checkOutput("midburst_reset_busy", 32'(busy), 32'd0);
    modelReset();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < D; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b1, AW'(i), 3'd0, 1'b1);
      checkOutput($sformatf("post_reset_read%0d", i), 32'(dout), 32'd0);
    end

    // Directed vectors: single read, wrap burst, back-to-back bursts.
    for (int i = 0; i < 8; i++) vecs[i] = mk(1, i, i, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    vecs[8]  = mk(1, 3, 10, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 1, 3, 0, 1, 1, 1, 10, 1, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    vecs[11] = mk(1, 3, 3, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 1, 6, 3, 1, 1, 1, 6, 0, 1);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 7, 0, 1);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    vecs[17] = mk(0, 0, 0, 1, 0, 1, 1, 1, 1, 0, 0, 1);
    vecs[18] = mk(0, 0, 0, 1, 4, 0, 1, 0, 1, 1, 1, 0);
    vecs[19] = mk(0, 0, 0, 1, 4, 0, 1, 1, 1, 4, 1, 0);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].rv,
                    vecs[i].raddr, vecs[i].rlen, vecs[i].dr);
      checkOutput($sformatf("vec%0d_ready", i), 32'(pre_ready), 32'(vecs[i].e_ready));
      checkOutput($sformatf("vec%0d_dvalid", i), 32'(dvalid), 32'(vecs[i].e_dvalid));
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      if (vecs[i].e_dvalid) begin
        checkOutput($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].e_dout));
        checkOutput($sformatf("vec%0d_dlast", i), 32'(dlast), 32'(vecs[i].e_dlast));
      end
    end

    // Wrap burst under backpressure: the same four beats must arrive in order.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_beats = '{6, 7, 0, 1};
    taken.delete();
    taken_last.delete();
    applyStimulus(1'b0, '0, '0, 1'b1, 3'd6, 3'd3, 1'b1);
    for (int k = 1; k < 40 && taken.size() < 4; k++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, pat[k % 4]);
    end
    checkOutput("bp_beat_count", 32'(taken.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < taken.size()) begin
        checkOutput($sformatf("bp_beat%0d", i), 32'(taken[i]), 32'(exp_beats[i]));
        checkOutput($sformatf("bp_last%0d", i), 32'(taken_last[i]), 32'(i == 3));
      end
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);

    // Write-first forwarding at issue, then a stalled beat must not follow a rewrite.
    applyStimulus(1'b1, 3'd5, 4'd5, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b1, 3'd5, 4'hC, 1'b1, 3'd5, 3'd0, 1'b0);
    checkOutput("fwd_dout", 32'(dout), 32'hC);
    applyStimulus(1'b1, 3'd5, 4'h3, 1'b0, '0, '0, 1'b0);
    checkOutput("snap_dout", 32'(dout), 32'hC);
    checkOutput("snap_dvalid", 32'(dvalid), 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 3'd5, 3'd0, 1'b1);
    checkOutput("rewrite_dout", 32'(dout), 32'h3);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, D - 1)), W'($urandom),
                    1'($urandom_range(0, 2) != 0), AW'($urandom_range(0, D - 1)),
                    AW'($urandom_range(0, D - 1)), 1'($urandom_range(0, 3) != 0));
    end
    for (int n = 0; n < 12; n++) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
